trigger_capture_ctrl: RTL and testbench
=======================================

Name: trigger_capture_ctrl

Overview:
- Sits directly downstream of the ADC interface and consumes its simple-interface sample stream (data/rdy/ack).
- Detects a level/edge trigger on the sample stream with a configurable pre-trigger depth.
- Writes one capture window into an external circular sample RAM through a registered write port.
- Reports the window start address and completion to the host-side readout logic.

Parameters:
- DATA_WIDTH, 8, sample width; matches the ADC interface.
- ADDR_WIDTH, 12, sample RAM address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  system clock (same clock as the ADC interface).
- rst  in  1  reset, synchronous, active-high; clock clk_i.
- SI_data  in  DATA_WIDTH  sample from the upstream stage.
- SI_rdy  in  1  sample valid.
- SI_ack  out  1  sample accepted.
- start  in  1  one-cycle pulse; arms a capture.
- abort  in  1  one-cycle pulse; returns to IDLE.
- force_trig  in  1  one-cycle pulse; forces a trigger (auto mode).
- trig_level  in  DATA_WIDTH  trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- pretrig_samples  in  ADDR_WIDTH+1  samples kept before the trigger.
- num_samples  in  ADDR_WIDTH+1  total window length.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  high in PRE, ARMED and POST.
- triggered  out  1  high from trigger until the next start.
- done  out  1  high in DONE.
- start_addr  out  ADDR_WIDTH  address of the first sample of the window.

Behaviour:
- Reset: state IDLE; all registered outputs, counters and the write pointer are 0. Reset mid-capture aborts immediately with no further writes.
- Handshake:
  - SI_ack = SI_rdy, combinational, in every state; the block never stalls the ADC.
  - A sample is accepted in a cycle when SI_rdy is high.
  - Samples accepted in IDLE or DONE are discarded.
- Configuration latch: on start in IDLE or DONE, latch trig_level, trig_edge, N = num_samples and P = pretrig_samples.
  - N = 0 or N > DEPTH: use N = DEPTH.
  - P >= N: use P = N-1.
  - Clear triggered, done, the sample counter and the prev-valid flag. wr_addr continues from its current value.
  - start during busy is ignored.
- Write port: each accepted sample in PRE, ARMED or POST drives wr_en=1, wr_data=sample, wr_addr=ptr on the next cycle (latency 1). ptr then increments modulo DEPTH, so wrap DEPTH-1 -> 0 is natural.
- Trigger condition, evaluated on the accepted sample cur against the previous accepted sample prev:
  - Rising (trig_edge=0): prev < level AND cur >= level.
  - Falling (trig_edge=1): prev > level AND cur <= level.
  - Requires prev-valid; the first sample after start can never trigger.
- force_trig: a pulse in ARMED sets force_pend, which makes the next accepted sample in ARMED the trigger sample. The pulse is ignored in other states. force_pend clears on trigger, start, abort and rst.
- State machine:
  - IDLE: on start -> PRE, or -> ARMED if P = 0.
  - PRE: write samples and count them. After the P-th accepted sample -> ARMED. Trigger conditions are ignored, but prev is still tracked.
  - ARMED: keep writing circularly. On a trigger sample:
    - record trig_addr = its write address;
    - start_addr = trig_addr - P mod DEPTH;
    - triggered = 1;
    - post counter = N-P-1;
    - -> POST, or -> DONE directly if N-P-1 = 0.
  - POST: write samples and decrement the post counter. The sample that brings it to 0 is the last written; the state becomes DONE in the same cycle that sample is accepted, so its wr_en appears the next cycle.
  - DONE: done = 1; hold start_addr; wait for start.
  - abort (any state except IDLE): -> IDLE. No write issued for a sample accepted in the abort cycle. done and triggered are cleared.
- Simultaneous events:
  - abort beats start and sample acceptance.
  - A sample accepted in the start cycle is discarded; capture begins with the next sample.
- Window: exactly N samples, P before the trigger sample, ending at trig_addr + N-P-1 mod DEPTH.

Decomposition:
- Shared package/defines: state encoding constants (IDLE, PRE, ARMED, POST, DONE) and the TRIG_RISING/TRIG_FALLING encodings, next to the existing HDL_defines.
- One natural sub-module, trigger_comparator: prev register, prev-valid flag and edge compare. It outputs a single trig_hit qualified by sample acceptance.

Test Plan:
- Basic rising: level=0x80, edge=0, P=4, N=16, ramp 0x00, 0x10, ... (step 0x10) continuously valid.
  - Trigger on sample 0x80; start_addr = trig_addr-4.
  - Exactly 16 wr_en pulses after the trigger window opens; done after the 12th post-trigger-inclusive write.
- Falling edge with idle gaps: SI_rdy toggling 1-0-1, level=0x40, edge=1, data 0x60, 0x50, 0x40.
  - Trigger on 0x40; wr_en only on accepted cycles, each one cycle after acceptance.
- Pre-trigger masking: P=8; an edge occurs at sample 3.
  - No trigger; the state stays PRE until 8 samples, then triggers on the next qualifying edge.
- Wrap-around: ADDR_WIDTH=4, ptr preloaded to 14 via prior captures, N=16, P=2.
  - Addresses wrap 15 -> 0; start_addr = (trig_addr-2) mod 16.
- Force trigger: constant data 0x55, force_trig pulse in ARMED.
  - Next sample is the trigger; triggered=1; N-P-1 further writes.
- Abort/reset mid-POST: abort asserted with SI_rdy high.
  - No write for that sample; busy=0, done=0 next cycle.
  - Repeat the same stimulus with rst instead of abort; all outputs return to 0.

Source files
------------

// File: rtl/trigger_capture_ctrl_pkg.sv
// Shared encodings for the trigger/capture controller.
package trigger_capture_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic TRIG_RISING  = 1'b0;
   localparam logic TRIG_FALLING = 1'b1;

endpackage

// File: rtl/trigger_capture_ctrl_comparator.sv
// Edge detector: remembers the previous accepted sample and flags a level
// crossing in the configured direction on the current accepted sample.
module trigger_comparator
   import trigger_capture_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst,
   input  logic                  clr_i,      // new capture: forget history
   input  logic                  acc_i,      // sample accepted into the capture
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] level_i,
   input  logic                  edge_i,
   output logic                  trig_hit_o
);

   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic                  prev_vld_q, prev_vld_d;
   logic                  rise, fall;

   // Track the last accepted sample; the first sample after a start has no predecessor.
   always_comb begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      if (clr_i) begin
         prev_vld_d = 1'b0;
      end else if (acc_i) begin
         prev_d     = data_i;
         prev_vld_d = 1'b1;
      end
   end

   // History registers.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
      end
   end

   assign rise       = (prev_q < level_i) && (data_i >= level_i);
   assign fall       = (prev_q > level_i) && (data_i <= level_i);
   assign trig_hit_o = acc_i && prev_vld_q && ((edge_i == TRIG_FALLING) ? fall : rise);

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Trigger/capture controller: streams ADC samples into a circular RAM,
// keeping a pre-trigger history and stopping after the post-trigger tail.
module trigger_capture_ctrl
   import trigger_capture_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] SI_data,
   input  logic                  SI_rdy,
   output logic                  SI_ack,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  force_trig,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic                  trig_edge,
   input  logic [ADDR_WIDTH:0]   pretrig_samples,
   input  logic [ADDR_WIDTH:0]   num_samples,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] start_addr
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] level_q, level_d;
   logic                  edge_q, edge_d;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic [ADDR_WIDTH:0]   p_q, p_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  force_pend_q, force_pend_d;
   logic                  triggered_q, triggered_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;

   logic                  active, cap, start_go, trig, trig_hit;
   logic [ADDR_WIDTH:0]   n_eff, p_eff, post_len;

   // The ADC is never back-pressured.
   assign SI_ack   = SI_rdy;
   assign active   = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
   assign cap      = SI_rdy && active && !abort;
   assign start_go = start && !abort && ((state_q == IDLE) || (state_q == DONE));
   assign n_eff    = ((num_samples == '0) || (num_samples > DEPTH_V)) ? DEPTH_V : num_samples;
   assign p_eff    = (pretrig_samples >= n_eff) ? (n_eff - CNT_ONE) : pretrig_samples;
   assign post_len = n_q - p_q - CNT_ONE;
   assign trig     = cap && (state_q == ARMED) && (trig_hit || force_pend_q);

   trigger_comparator #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp (
      .clk_i      (clk_i),
      .rst        (rst),
      .clr_i      (start_go),
      .acc_i      (cap),
      .data_i     (SI_data),
      .level_i    (level_q),
      .edge_i     (edge_q),
      .trig_hit_o (trig_hit)
   );

   // Next-state: write port, capture phases and status flags.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      wr_en_d      = cap;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      level_d      = level_q;
      edge_d       = edge_q;
      n_d          = n_q;
      p_d          = p_q;
      cnt_d        = cnt_q;
      force_pend_d = force_pend_q;
      triggered_d  = triggered_q;
      done_d       = done_q;
      start_addr_d = start_addr_q;

      // Every captured sample lands at the running pointer one cycle later.
      if (cap) begin
         wr_addr_d = ptr_q;
         wr_data_d = SI_data;
         ptr_d     = ptr_q + ADDR_ONE;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start_go) begin
               level_d      = trig_level;
               edge_d       = trig_edge;
               n_d          = n_eff;
               p_d          = p_eff;
               cnt_d        = '0;
               force_pend_d = 1'b0;
               triggered_d  = 1'b0;
               done_d       = 1'b0;
               state_d      = (p_eff == '0) ? ARMED : PRE;
            end
         end
         PRE: begin
            if (cap) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q + CNT_ONE == p_q) state_d = ARMED;
            end
         end
         ARMED: begin
            if (trig) begin
               start_addr_d = ptr_q - p_q[ADDR_WIDTH-1:0];
               triggered_d  = 1'b1;
               force_pend_d = 1'b0;
               cnt_d        = post_len;
               if (post_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = POST;
               end
            end else if (force_trig) begin
               force_pend_d = 1'b1;
            end
         end
         POST: begin
            if (cap) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over start and over any sample in the same cycle.
      if (abort && (state_q != IDLE)) begin
         state_d      = IDLE;
         done_d       = 1'b0;
         triggered_d  = 1'b0;
         force_pend_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         level_q      <= '0;
         edge_q       <= 1'b0;
         n_q          <= '0;
         p_q          <= '0;
         cnt_q        <= '0;
         force_pend_q <= 1'b0;
         triggered_q  <= 1'b0;
         done_q       <= 1'b0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         level_q      <= level_d;
         edge_q       <= edge_d;
         n_q          <= n_d;
         p_q          <= p_d;
         cnt_q        <= cnt_d;
         force_pend_q <= force_pend_d;
         triggered_q  <= triggered_d;
         done_q       <= done_d;
         start_addr_q <= start_addr_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = active;
   assign triggered  = triggered_q;
   assign done       = done_q;
   assign start_addr = start_addr_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Scoreboard bench for trigger_capture_ctrl with a 16-entry RAM so wrap-around
// is exercised constantly. Expected writes are queued by a window-level model.
module tb_trigger_capture_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk_i = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] SI_data = '0;
   logic          SI_rdy = 1'b0;
   logic          SI_ack;
   logic          start = 1'b0, abort = 1'b0, force_trig = 1'b0;
   logic [DW-1:0] trig_level = '0;
   logic          trig_edge = 1'b0;
   logic [AW:0]   pretrig_samples = '0, num_samples = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy, triggered, done;
   logic [AW-1:0] start_addr;

   always #5 clk_i = ~clk_i;

   trigger_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rst(rst), .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
      .start(start), .abort(abort), .force_trig(force_trig),
      .trig_level(trig_level), .trig_edge(trig_edge),
      .pretrig_samples(pretrig_samples), .num_samples(num_samples),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .triggered(triggered), .done(done), .start_addr(start_addr)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Window-level reference: samples since start, trigger index, window bounds.
   typedef struct {int cyc; int addr; int data;} wr_t;
   wr_t      exp_q[$];
   int       hist[$];
   int       trig_idx, n_m, p_m, ptr_m, sa_m, level_m;
   bit       edge_m, running, done_m, trig_m, pend_m;

   task automatic model_cycle();
      int  idx, prev, d;
      bit  armed0, hit;
      if (rst) begin
         running = 0; done_m = 0; trig_m = 0; pend_m = 0; sa_m = 0; ptr_m = 0;
         hist.delete();
      end else if (abort) begin
         if (running || done_m) begin
            running = 0; done_m = 0; trig_m = 0; pend_m = 0;
         end
      end else if (start && !running) begin
         n_m = int'(num_samples);
         if (n_m == 0 || n_m > DEPTH) n_m = DEPTH;
         p_m = int'(pretrig_samples);
         if (p_m >= n_m) p_m = n_m - 1;
         level_m = int'(trig_level); edge_m = trig_edge;
         hist.delete(); trig_idx = -1;
         running = 1; done_m = 0; trig_m = 0; pend_m = 0;
      end else if (running) begin
         armed0 = (trig_idx < 0) && (hist.size() >= p_m);
         hit = 0;
         if (SI_rdy) begin
            d   = int'(SI_data);
            idx = hist.size();
            if (trig_idx < 0 && idx >= p_m) begin
               if (pend_m) hit = 1;
               else if (idx >= 1) begin
                  prev = hist[idx-1];
                  hit = edge_m ? (prev > level_m && d <= level_m)
                               : (prev < level_m && d >= level_m);
               end
            end
            hist.push_back(d);
            exp_q.push_back('{cyc + 1, ptr_m, d});
            if (hit) begin
               trig_idx = idx; trig_m = 1;
               sa_m = ((ptr_m - p_m) % DEPTH + DEPTH) % DEPTH;
            end
            ptr_m = (ptr_m + 1) % DEPTH;
            if (trig_idx >= 0 && idx - trig_idx == n_m - p_m - 1) begin
               running = 0; done_m = 1;
            end
         end
         if (hit) pend_m = 0;
         else if (force_trig && armed0) pend_m = 1;
      end
   endtask

   task automatic step(input bit r, input int d, input bit s = 0, input bit a = 0,
                       input bit f = 0, input bit rs = 0);
      SI_rdy = r; SI_data = DW'(d); start = s; abort = a; force_trig = f; rst = rs;
      model_cycle();
      @(negedge clk_i);
   endtask

   task automatic cfg(input int lvl, input bit e, input int n, input int p);
      trig_level = DW'(lvl); trig_edge = e;
      num_samples = (AW+1)'(n); pretrig_samples = (AW+1)'(p);
      step(0, 0, 1);
   endtask

   // Monitor: checks every write against the queue and the status outputs each cycle.
   always @(posedge clk_i) begin
      wr_t e;
      cyc <= cyc + 1;
      #1;
      if (wr_en) begin
         if (exp_q.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_data", int'(wr_data), e.data);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         chk("wr_missing", int'(wr_en), 1);
         void'(exp_q.pop_front());
      end
      chk("busy", int'(busy), int'(running));
      chk("done", int'(done), int'(done_m));
      chk("triggered", int'(triggered), int'(trig_m));
      chk("start_addr", int'(start_addr), sa_m);
      chk("si_ack", int'(SI_ack), int'(SI_rdy));
   end

   int fall_seq[7] = '{'h60, 'h50, 'h40, 'h30, 'h20, 'h10, 'h05};
   int mask_seq[16] = '{'h00, 'h10, 'h90, 'h00, 'h00, 'h00, 'h00, 'h00,
                        'h00, 'h90, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00};

   initial begin
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0);

      // Rising edge on a ramp.
      cfg('h80, 0, 16, 4);
      for (int i = 0; i < 30; i++) step(1, (i * 16) & 255);
      step(0, 0);

      // Falling edge with idle gaps between samples.
      cfg('h40, 1, 5, 1);
      for (int i = 0; i < 14; i++) step(i % 2 == 0, fall_seq[i/2]);
      step(0, 0);

      // Edge inside the pre-trigger region is ignored.
      cfg('h80, 0, 12, 8);
      for (int i = 0; i < 16; i++) step(1, mask_seq[i]);

      // N=0 means full depth; P clamps to N-1, so the trigger sample ends the window.
      cfg('h80, 0, 0, 20);
      for (int i = 0; i < 30; i++) step(1, (i * 16) & 255);

      // Full-depth window across the wrap point.
      cfg('h80, 0, 16, 2);
      for (int i = 0; i < 30; i++) step(1, (i * 16) & 255);

      // P >= N clamps to N-1.
      cfg('h30, 0, 5, 9);
      for (int i = 0; i < 24; i++) step(1, (i * 16) & 255);

      // Forced trigger on flat data.
      cfg('h80, 0, 6, 2);
      for (int i = 0; i < 4; i++) step(1, 'h55);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 'h55);

      // Abort mid-POST with a sample present, then the same with reset.
      cfg('h80, 0, 16, 2);
      for (int i = 0; i < 12; i++) step(1, (i * 16) & 255);
      step(1, 'hAA, 0, 1);
      step(0, 0); step(0, 0);
      cfg('h80, 0, 16, 2);
      for (int i = 0; i < 12; i++) step(1, (i * 16) & 255);
      step(1, 'hAA, 0, 0, 0, 1);
      step(0, 0); step(0, 0);

      // Random captures; config ports are scrambled mid-capture to check latching.
      for (int k = 0; k < 40; k++) begin
         cfg($urandom_range(0, 255), 1'($urandom_range(0, 1)),
             $urandom_range(0, 20), $urandom_range(0, 20));
         for (int c = 0; c < 80 && running; c++) begin
            trig_level = DW'($urandom); trig_edge = 1'($urandom);
            num_samples = (AW+1)'($urandom); pretrig_samples = (AW+1)'($urandom);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 255),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 19) == 0);
         end
         if (running) step(0, 0, 0, 1);
         step($urandom_range(0, 1) == 1, $urandom_range(0, 255));
      end

      step(0, 0); step(0, 0); step(0, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
